// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (skid buffer).
// Registered valid/ready on both sides with synchronous flush.
module pipe_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             Flush,
    input  logic             InValid,
    input  logic [WIDTH-1:0] InData,
    output logic             InReady,
    output logic             OutValid,
    output logic [WIDTH-1:0] OutData,
    input  logic             OutReady,
    output logic [1:0]       Occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    // Next-state and datapath: flush wins, then the handshake transitions
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (Flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (InValid) begin
                        main_d  = InData;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (InValid && OutReady) begin
                        main_d = InData;
                    end else if (InValid) begin
                        skid_d  = InData;
                        state_d = FULL;
                    end else if (OutReady) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (OutReady) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and storage registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Handshake outputs decoded purely from the state register;
    // a stray encoding accepts nothing until it falls back to EMPTY
    always_comb begin
        InReady   = 1'b0;
        OutValid  = 1'b0;
        Occupancy = 2'd0;
        case (state_q)
            EMPTY: begin
                InReady = 1'b1;
            end
            ONE: begin
                InReady   = 1'b1;
                OutValid  = 1'b1;
                Occupancy = 2'd1;
            end
            FULL: begin
                OutValid  = 1'b1;
                Occupancy = 2'd2;
            end
            default: begin
                InReady = 1'b0;
            end
        endcase
    end

    assign OutData = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_pipe_skid_reg;

    logic       clk = 1'b0;
    logic       resetn;
    logic       Flush;
    logic       InValid;
    logic [7:0] InData;
    logic       InReady;
    logic       OutValid;
    logic [7:0] OutData;
    logic       OutReady;
    logic [1:0] Occupancy;

    int npass  = 0;
    int ntotal = 0;
    bit chk_en = 1'b0;

    pipe_skid_reg #(.WIDTH(8)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .Flush    (Flush),
        .InValid  (InValid),
        .InData   (InData),
        .InReady  (InReady),
        .OutValid (OutValid),
        .OutData  (OutData),
        .OutReady (OutReady),
        .Occupancy(Occupancy)
    );

    always #5 clk = ~clk;

    // Reference: a FIFO of held entries plus the value left on the
    // head register once the FIFO has drained
    logic [7:0] mq[$];
    logic [7:0] mstale = 8'h00;
    bit         m_inf;
    bit         m_outf;
    bit         in_taken = 1'b0;

    always @(posedge clk) begin
        if (!resetn) begin
            mq.delete();
            mstale   = 8'h00;
            in_taken = 1'b0;
        end else begin
            m_inf    = InValid && (mq.size() < 2);
            m_outf   = (mq.size() > 0) && OutReady;
            in_taken = m_inf;
            if (Flush) begin
                mq.delete();
                mstale = 8'h00;
            end else begin
                if (m_outf) mstale = mq.pop_front();
                if (m_inf) mq.push_back(InData);
            end
        end
    end

    // Per-cycle comparison against the model
    logic       e_ov, e_ir;
    logic [1:0] e_oc;
    logic [7:0] e_od;

    always @(negedge clk) begin
        if (chk_en) begin
            e_ov = mq.size() > 0;
            e_ir = mq.size() < 2;
            e_oc = 2'(mq.size());
            e_od = (mq.size() > 0) ? mq[0] : mstale;
            ntotal++;
            if (OutValid === e_ov && InReady === e_ir &&
                Occupancy === e_oc && OutData === e_od) begin
                npass++;
            end else begin
                $display("FAIL model t=%0t got v=%b r=%b o=%0d d=%h want v=%b r=%b o=%0d d=%h",
                         $time, OutValid, InReady, Occupancy, OutData,
                         e_ov, e_ir, e_oc, e_od);
            end
        end
    end

    // Producer must keep an unaccepted offer stable
    logic       p_rst = 1'b0;
    logic       p_flush = 1'b0;
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b1;
    logic [7:0] p_data = 8'h00;

    always @(posedge clk) begin
        if (resetn && p_rst && p_valid && !p_ready && !p_flush) begin
            assert (InValid && InData == p_data)
            else $error("FAIL in_hold got v=%b d=%h want v=1 d=%h",
                        InValid, InData, p_data);
        end
        p_rst   <= resetn;
        p_flush <= Flush;
        p_valid <= InValid;
        p_ready <= InReady;
        p_data  <= InData;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ov"}, 32'(OutValid), 32'd0);
        chk({nm, "_ir"}, 32'(InReady), 32'd1);
        chk({nm, "_oc"}, 32'(Occupancy), 32'd0);
        chk({nm, "_od"}, 32'(OutData), 32'h00);
    endtask

    initial begin
        resetn   = 1'b0;
        Flush    = 1'b0;
        InValid  = 1'b1;
        InData   = 8'hAA;
        OutReady = 1'b0;

        // Reset with a pending offer
        cyc();
        chk_en = 1'b1;
        chk_reset_vals("rst1");
        cyc();
        chk_reset_vals("rst2");
        resetn = 1'b1;
        cyc();
        chk("rel_od", 32'(OutData), 32'hAA);
        chk("rel_ov", 32'(OutValid), 32'd1);
        chk("rel_oc", 32'(Occupancy), 32'd1);

        InValid  = 1'b0;
        OutReady = 1'b1;
        cyc();
        chk("empty_oc", 32'(Occupancy), 32'd0);

        // Back-to-back streaming
        for (int i = 1; i <= 16; i++) begin
            InValid = 1'b1;
            InData  = 8'(i);
            cyc();
            chk("stream_od", 32'(OutData), 32'(i));
            chk("stream_oc", 32'(Occupancy), 32'd1);
        end
        InValid = 1'b0;
        cyc();
        chk("stream_end_ov", 32'(OutValid), 32'd0);

        // Stall and skid
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'h11;
        cyc();
        InData = 8'h22;
        cyc();
        chk("full_ir", 32'(InReady), 32'd0);
        chk("full_od", 32'(OutData), 32'h11);
        chk("full_oc", 32'(Occupancy), 32'd2);
        InData = 8'h33;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_oc", 32'(Occupancy), 32'd2);
            chk("hold_od", 32'(OutData), 32'h11);
        end
        OutReady = 1'b1;
        chk("rel0_od", 32'(OutData), 32'h11);
        cyc();
        chk("rel1_od", 32'(OutData), 32'h22);
        chk("rel1_ov", 32'(OutValid), 32'd1);
        cyc();
        chk("rel2_od", 32'(OutData), 32'h33);
        chk("rel2_ov", 32'(OutValid), 32'd1);
        InValid = 1'b0;
        cyc();
        chk("rel3_oc", 32'(Occupancy), 32'd0);

        // Drain to empty
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'h5A;
        cyc();
        chk("drain_od", 32'(OutData), 32'h5A);
        InValid  = 1'b0;
        OutReady = 1'b1;
        cyc();
        chk("drain_ov", 32'(OutValid), 32'd0);
        chk("drain_oc", 32'(Occupancy), 32'd0);
        cyc();
        chk("drain2_oc", 32'(Occupancy), 32'd0);

        // Flush while FULL
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'h11;
        cyc();
        InData = 8'h22;
        cyc();
        chk("pre_flush_oc", 32'(Occupancy), 32'd2);
        InValid  = 1'b0;
        Flush    = 1'b1;
        OutReady = 1'b1;
        cyc();
        chk_reset_vals("flush_full");
        Flush = 1'b0;
        cyc();
        chk("post_flush_ov", 32'(OutValid), 32'd0);

        // Flush drops a same-cycle input in ONE
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'h44;
        cyc();
        InData = 8'h77;
        Flush  = 1'b1;
        cyc();
        chk_reset_vals("flush_one");
        Flush   = 1'b0;
        InValid = 1'b0;
        cyc();
        chk("drop77_oc", 32'(Occupancy), 32'd0);
        chk("drop77_od", 32'(OutData), 32'h00);

        // Reset while FULL
        InValid = 1'b1;
        InData  = 8'h11;
        cyc();
        InData = 8'h22;
        cyc();
        InValid  = 1'b0;
        resetn   = 1'b0;
        OutReady = 1'b1;
        cyc();
        chk_reset_vals("rst_mid");
        resetn   = 1'b1;
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 8'hC3;
        cyc();
        chk("after_rst_od", 32'(OutData), 32'hC3);
        chk("after_rst_oc", 32'(Occupancy), 32'd1);
        InValid  = 1'b0;
        OutReady = 1'b1;
        cyc();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            resetn   = ($urandom_range(0, 199) != 0);
            Flush    = ($urandom_range(0, 39) == 0);
            OutReady = ($urandom_range(0, 2) != 0);
            if (!(InValid && !in_taken)) begin
                InValid = ($urandom_range(0, 3) != 0);
                InData  = 8'($urandom);
            end
            cyc();
        end

        resetn   = 1'b1;
        Flush    = 1'b0;
        OutReady = 1'b1;
        for (int n = 0; n < 4; n++) begin
            InValid = 1'b0;
            cyc();
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
